// File: rtl/buffer_input.sv
// DTN receive buffer: accepts messages addressed to OWN_ADDR into a DEPTH-entry
// FIFO and presents the oldest word first-word-fall-through to the functional unit.
module buffer_input #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] OWN_ADDR   = '0,
    parameter int                    DEPTH      = 5
) (
    input  logic                         clock,
    input  logic                         reset_n,
    // DTN consumer side
    input  logic [ADDR_WIDTH-1:0]        dtn_from,
    input  logic [ADDR_WIDTH-1:0]        dtn_to,
    input  logic [DATA_WIDTH-1:0]        dtn_data,
    input  logic                         dtn_valid,
    output logic                         dtn_ack,
    // Functional-unit producer side
    output logic [DATA_WIDTH-1:0]        data_data,
    output logic                         data_valid,
    input  logic                         data_ack,
    output logic [ADDR_WIDTH-1:0]        data_from,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_from [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // DEPTH need not be a power of two, so wrap by compare rather than masking.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign full  = (level == LVL_FULL);
    assign empty = (level == '0);

    // No pass-through at full: a same-cycle pop does not free the slot for a push.
    assign dtn_ack    = reset_n && dtn_valid && (dtn_to == OWN_ADDR) && !full;
    assign data_valid = !empty;
    assign data_data  = mem_data[rd_ptr];
    assign data_from  = mem_from[rd_ptr];

    assign push = dtn_ack;
    assign pop  = data_valid && data_ack;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_data[wr_ptr] <= dtn_data;
            mem_from[wr_ptr] <= dtn_from;
        end
    end

endmodule

// File: tb/tb_buffer_input.sv
// Directed bench for buffer_input: reset, fill/drain, pointer wrap, simultaneous
// push/pop, misaddressed traffic and asynchronous reset while occupied.
module tb_buffer_input;

    localparam int                ADDR_WIDTH = 8;
    localparam int                DATA_WIDTH = 32;
    localparam int                DEPTH      = 5;
    localparam logic [7:0]        OWN        = 8'h21;
    localparam int                LVL_W      = $clog2(DEPTH + 1);

    logic                  clock = 1'b0;
    logic                  reset_n;
    logic [ADDR_WIDTH-1:0] dtn_from;
    logic [ADDR_WIDTH-1:0] dtn_to;
    logic [DATA_WIDTH-1:0] dtn_data;
    logic                  dtn_valid;
    logic                  dtn_ack;
    logic [DATA_WIDTH-1:0] data_data;
    logic                  data_valid;
    logic                  data_ack;
    logic [ADDR_WIDTH-1:0] data_from;
    logic [LVL_W-1:0]      level;

    int checks = 0;
    int errors = 0;

    buffer_input #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .OWN_ADDR  (OWN),
        .DEPTH     (DEPTH)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .dtn_from  (dtn_from),
        .dtn_to    (dtn_to),
        .dtn_data  (dtn_data),
        .dtn_valid (dtn_valid),
        .dtn_ack   (dtn_ack),
        .data_data (data_data),
        .data_valid(data_valid),
        .data_ack  (data_ack),
        .data_from (data_from),
        .level     (level)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [7:0] from, input logic [31:0] d);
        dtn_valid = 1'b1;
        dtn_to    = OWN;
        dtn_from  = from;
        dtn_data  = d;
        #1;
        chk("push_ack", dtn_ack, 1);
        tick();
        dtn_valid = 1'b0;
    endtask

    task automatic pop_expect(input logic [31:0] d, input logic [7:0] from);
        data_ack = 1'b1;
        #1;
        chk("pop_valid", data_valid, 1);
        chk("pop_data", data_data, d);
        chk("pop_from", data_from, from);
        tick();
        data_ack = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        dtn_from  = '0;
        dtn_to    = OWN;
        dtn_data  = '0;
        dtn_valid = 1'b1;
        data_ack  = 1'b0;

        // 1: reset holds ack low even with a matching request
        tick();
        tick();
        chk("rst_ack", dtn_ack, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_level", level, 0);
        reset_n = 1'b1;
        #1;
        chk("rel_ack", dtn_ack, 1);
        dtn_valid = 1'b0;
        tick();
        chk("rel_level", level, 0);

        // 2: fill to full, then drain in order
        for (int i = 0; i < DEPTH; i++) begin
            chk("fill_level_pre", level, i);
            push_word(8'h03, 32'h10 + i);
            chk("fill_level", level, i + 1);
            chk("fill_head", data_data, 32'h10);
        end
        dtn_valid = 1'b1;
        dtn_data  = 32'h15;
        #1;
        chk("full_ack", dtn_ack, 0);
        tick();
        dtn_valid = 1'b0;
        chk("full_level", level, 5);
        for (int i = 0; i < DEPTH; i++) begin
            pop_expect(32'h10 + i, 8'h03);
            chk("drain_level", level, DEPTH - 1 - i);
        end
        chk("drain_valid", data_valid, 0);

        // 3: pointer wrap
        for (int i = 0; i < 3; i++) push_word(8'h07, 32'h100 + i);
        for (int i = 0; i < 3; i++) pop_expect(32'h100 + i, 8'h07);
        for (int i = 0; i < 5; i++) push_word(8'h40 + i, 32'h200 + i);
        chk("wrap_level", level, 5);
        for (int i = 0; i < 5; i++) pop_expect(32'h200 + i, 8'h40 + i);
        chk("wrap_empty", level, 0);

        // 4: simultaneous push/pop at level 2, then pop while full
        push_word(8'h01, 32'hA0);
        push_word(8'h02, 32'hA1);
        dtn_valid = 1'b1;
        dtn_from  = 8'h09;
        dtn_data  = 32'hAA;
        data_ack  = 1'b1;
        #1;
        chk("sim_ack", dtn_ack, 1);
        chk("sim_head", data_data, 32'hA0);
        tick();
        dtn_valid = 1'b0;
        data_ack  = 1'b0;
        chk("sim_level", level, 2);
        pop_expect(32'hA1, 8'h02);
        pop_expect(32'hAA, 8'h09);
        chk("sim_empty", level, 0);
        for (int i = 0; i < 5; i++) push_word(8'h0C, 32'hB0 + i);
        dtn_valid = 1'b1;
        dtn_data  = 32'hBF;
        data_ack  = 1'b1;
        #1;
        chk("fullpop_ack", dtn_ack, 0);
        tick();
        dtn_valid = 1'b0;
        data_ack  = 1'b0;
        chk("fullpop_level", level, 4);
        for (int i = 1; i < 5; i++) pop_expect(32'hB0 + i, 8'h0C);
        chk("fullpop_empty", level, 0);

        // 5: misaddressed traffic is ignored
        dtn_valid = 1'b1;
        dtn_to    = OWN + 8'h01;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("mis_ack", dtn_ack, 0);
            tick();
        end
        dtn_valid = 1'b0;
        dtn_to    = OWN;
        chk("mis_level", level, 0);
        chk("mis_valid", data_valid, 0);

        // 6: asynchronous reset mid-cycle while occupied
        for (int i = 0; i < 3; i++) push_word(8'h05, 32'hC0 + i);
        chk("ar_level_pre", level, 3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", data_valid, 0);
        chk("ar_level", level, 0);
        tick();
        #3;
        reset_n = 1'b1;
        tick();
        chk("ar_rel_level", level, 0);
        chk("ar_rel_valid", data_valid, 0);
        push_word(8'h06, 32'h77);
        pop_expect(32'h77, 8'h06);
        chk("ar_final_level", level, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
